// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by the system bus and peripheral ports.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/periph_obi_guard_pkg.sv
// Shared definitions for the peripheral OBI guard: FSM states, the default
// error read data and the timeout counter width helper.
package periph_obi_guard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } guard_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;

    // Bits needed to hold a count from 0 up to and including timeout_cycles.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/periph_obi_guard_timer.sv
// Response-phase cycle counter for the peripheral OBI guard.
// Loaded with 1 on the request handshake, incremented once per waiting cycle,
// and flags when it has reached TIMEOUT_CYCLES.
module periph_obi_guard_timer
    import periph_obi_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);

    logic [CntW-1:0] count;

    // Load takes priority so a new transaction always restarts from 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (load_i) begin
            count <= CntW'(1);
        end else if (inc_i) begin
            count <= count + 1'b1;
        end
    end

    // Terminal-count compare.
    always_comb begin
        expired_o = (count == CntW'(TIMEOUT_CYCLES));
    end

endmodule

// File: rtl/periph_obi_guard.sv
// Peripheral OBI guard: allows one outstanding transaction to the peripheral
// subsystem and, when PERIPH_OBI_GUARD_TIMEOUT_EN is defined, answers a
// transaction that never gets its response with ERR_RDATA after
// TIMEOUT_CYCLES, then swallows the late genuine response in DRAIN.
// Without PERIPH_OBI_GUARD_TIMEOUT_EN the guard only serialises transactions.
module periph_obi_guard
    import obi_pkg::*;
    import periph_obi_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  obi_req_t   slave_req_i,
    output obi_resp_t  slave_resp_o,
    output obi_req_t   master_req_o,
    input  obi_resp_t  master_resp_i,
    input  logic       clear_i,
    output logic       timeout_irq_o,
    output logic [7:0] timeout_count_o
);

    guard_state_e state;
    guard_state_e state_next;
    logic         handshake;
    logic         timeout_fire;

    assign handshake = (state == IDLE) && slave_req_i.req && master_resp_i.gnt;

`ifdef PERIPH_OBI_GUARD_TIMEOUT_EN
    logic       expired;
    logic       irq;
    logic [7:0] count;

    periph_obi_guard_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (handshake),
        .inc_i    ((state == WAIT) && !master_resp_i.rvalid && !expired),
        .expired_o(expired)
    );

    // A genuine response in the terminal cycle wins over the timeout.
    assign timeout_fire = (state == WAIT) && expired && !master_resp_i.rvalid;

    // Sticky flag: a timeout in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq <= 1'b0;
        end else if (timeout_fire) begin
            irq <= 1'b1;
        end else if (clear_i) begin
            irq <= 1'b0;
        end
    end

    // Saturating count of forced responses, independent of clear_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (timeout_fire && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign timeout_irq_o   = irq;
    assign timeout_count_o = count;
`else
    logic unused_cfg;

    assign timeout_fire    = 1'b0;
    assign timeout_irq_o   = 1'b0;
    assign timeout_count_o = '0;
    assign unused_cfg      = clear_i ^ (TIMEOUT_CYCLES == 0);
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request gating, response steering and next-state selection.
    always_comb begin
        master_req_o = slave_req_i;
        slave_resp_o = '0;
        state_next   = state;
        case (state)
            IDLE: begin
                slave_resp_o.gnt = master_resp_i.gnt;
                if (handshake) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                master_req_o.req = 1'b0;
                if (master_resp_i.rvalid) begin
                    slave_resp_o.rvalid = 1'b1;
                    slave_resp_o.rdata  = master_resp_i.rdata;
                    state_next          = IDLE;
                end else if (timeout_fire) begin
                    slave_resp_o.rvalid = 1'b1;
                    slave_resp_o.rdata  = ERR_RDATA;
                    state_next          = DRAIN;
                end
            end
            DRAIN: begin
                master_req_o.req = 1'b0;
                if (master_resp_i.rvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_periph_obi_guard.sv
// Scoreboard bench for periph_obi_guard (TIMEOUT_CYCLES = 4).
// Honours PERIPH_OBI_GUARD_TIMEOUT_EN: the reference model predicts forced
// responses only when the macro is defined.
module tb_periph_obi_guard;
    import obi_pkg::*;

    localparam int unsigned T   = 4;
    localparam logic [31:0] ERR = 32'hBADCAB1E;
`ifdef PERIPH_OBI_GUARD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       clear_i = 1'b0;
    obi_req_t   slave_req_i;
    obi_resp_t  slave_resp_o;
    obi_req_t   master_req_o;
    obi_resp_t  master_resp_i;
    logic       timeout_irq_o;
    logic [7:0] timeout_count_o;

    periph_obi_guard #(
        .TIMEOUT_CYCLES(T),
        .ERR_RDATA     (32'hBADCAB1E)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .slave_req_i    (slave_req_i),
        .slave_resp_o   (slave_resp_o),
        .master_req_o   (master_req_o),
        .master_resp_i  (master_resp_i),
        .clear_i        (clear_i),
        .timeout_irq_o  (timeout_irq_o),
        .timeout_count_o(timeout_count_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Downstream slave behaviour per transaction: response latency in cycles
    // after the grant cycle, and the data it returns.
    typedef struct { int unsigned lat; logic [31:0] data; } slv_t;
    // What the system bus must see for each accepted transaction.
    typedef struct { logic [31:0] rdata; bit forced; } exp_t;

    slv_t lat_q[$];
    exp_t exp_q[$];
    bit   busy = 1'b0;
    bit   abandoned = 1'b0;

    // Downstream peripheral model: random grants, one response per accepted request.
    initial begin
        slv_t        cur;
        int unsigned sc;
        cur = '{lat: 0, data: '0};
        sc  = 0;
        master_resp_i = '0;
        forever begin
            @(negedge clk);
            if (busy && !abandoned) check("gnt_blocked_while_busy", 32'(slave_resp_o.gnt), 0);
            if (busy && master_resp_i.rvalid) begin
                busy      = 1'b0;
                abandoned = 1'b0;
            end
            if (rst_ni && master_req_o.req && master_resp_i.gnt) begin
                check("no_downstream_overlap", 32'(busy), 0);
                check("grant_has_txn", 32'(lat_q.size() > 0), 1);
                if (lat_q.size() > 0) begin
                    cur  = lat_q.pop_front();
                    busy = 1'b1;
                    sc   = 0;
                end
            end
            @(posedge clk);
            #1;
            master_resp_i.gnt    = ($urandom_range(3) != 0);
            master_resp_i.rvalid = 1'b0;
            master_resp_i.rdata  = $urandom;
            if (busy) begin
                sc++;
                if (sc == cur.lat) begin
                    master_resp_i.rvalid = 1'b1;
                    master_resp_i.rdata  = cur.data;
                end
            end
        end
    end

    bit          exp_irq = 1'b0;
    int unsigned exp_cnt = 0;

    // Monitor: compares every upstream response against the scoreboard and
    // tracks the sticky flag and forced-response count.
    initial begin
        exp_t e;
        bit   forced;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                exp_irq = 1'b0;
                exp_cnt = 0;
            end else begin
                check("timeout_irq", 32'(timeout_irq_o), 32'(exp_irq));
                check("timeout_count", 32'(timeout_count_o), exp_cnt);
                forced = 1'b0;
                if (slave_resp_o.rvalid) begin
                    check("response_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("rdata", slave_resp_o.rdata, e.rdata);
                        forced = e.forced;
                    end
                end else begin
                    check("rdata_zero_when_idle", slave_resp_o.rdata, 0);
                end
                if (forced) begin
                    exp_irq = 1'b1;
                    if (exp_cnt < 255) exp_cnt++;
                end else if (clear_i) begin
                    exp_irq = 1'b0;
                end
            end
        end
    end

    // Issue one request; returns one cycle after the handshake with req still high.
    task automatic issue(input int unsigned lat, input logic [31:0] data, input bit we);
        bit forced;
        int n;
        forced = TO_EN && (lat > T);
        lat_q.push_back('{lat: lat, data: data});
        exp_q.push_back('{rdata: (forced ? ERR : data), forced: forced});
        slave_req_i.req   = 1'b1;
        slave_req_i.we    = we;
        slave_req_i.be    = 4'($urandom);
        slave_req_i.addr  = $urandom;
        slave_req_i.wdata = $urandom;
        n = 0;
        forever begin
            @(negedge clk);
            if (slave_resp_o.gnt) break;
            n++;
            if (n > 200) begin
                check("grant_within_budget", 0, 1);
                finish_tb();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned cycles);
        slave_req_i.req = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        slave_req_i.req = 1'b0;
        n = 0;
        while (busy || exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                check("drain_within_budget", 0, 1);
                finish_tb();
            end
        end
    endtask

    // Held in reset: registered outputs cleared, combinational IDLE pass-through.
    task automatic reset_checks();
        slave_req_i.req  = 1'b1;
        slave_req_i.addr = $urandom;
        #1;
        check("rst_irq", 32'(timeout_irq_o), 0);
        check("rst_count", 32'(timeout_count_o), 0);
        check("rst_rvalid", 32'(slave_resp_o.rvalid), 0);
        check("rst_rdata", slave_resp_o.rdata, 0);
        check("rst_pass_req", 32'(master_req_o.req), 1);
        check("rst_pass_addr", master_req_o.addr, slave_req_i.addr);
        check("rst_pass_gnt", 32'(slave_resp_o.gnt), 32'(master_resp_i.gnt));
        slave_req_i.req = 1'b0;
    endtask

    initial begin
        slave_req_i = '0;
        @(posedge clk);
        #3;
        reset_checks();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Read answered 3 cycles after grant.
        issue(3, 32'h12345678, 1'b0);
        wait_drain();
        // Response exactly in the terminal cycle: genuine data wins.
        issue(T, 32'hCAFEF00D, 1'b0);
        wait_drain();
        // Very late response, immediately followed by another request.
        issue(TO_EN ? T + 5 : T + 1, 32'h0BADF00D, 1'b0);
        issue(1, $urandom, 1'b1);
        wait_drain();
        // Back-to-back requests to a single-cycle slave.
        for (int i = 0; i < 8; i++) issue(1, $urandom, i[0]);
        wait_drain();

        // Randomized mix of latencies, directions and gaps.
        for (int i = 0; i < 150; i++) begin
            issue(TO_EN ? $urandom_range(T + 6, 1) : $urandom_range(10, 1), $urandom, 1'($urandom));
            if ($urandom_range(1) == 0) idle($urandom_range(2));
        end
        wait_drain();
        idle(2);

`ifdef PERIPH_OBI_GUARD_TIMEOUT_EN
        // Start from a cleared flag, then clear in the same cycle as a timeout.
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
        idle(1);
        check("irq_cleared", 32'(timeout_irq_o), 0);
        issue(T + 2, $urandom, 1'b1);
        repeat (T - 1) begin
            @(posedge clk);
            #1;
        end
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        check("irq_set_wins_over_clear", 32'(timeout_irq_o), 1);
        wait_drain();
        idle(2);
        clear_i = 1'b1;
        idle(1);
        clear_i = 1'b0;
        check("irq_clear_alone", 32'(timeout_irq_o), 0);
        idle(2);

        // Enough timeouts to saturate the counter.
        for (int i = 0; i < 300; i++) issue(T + 1 + $urandom_range(2), $urandom, 1'($urandom));
        wait_drain();
        idle(1);
        check("count_saturated", 32'(timeout_count_o), 255);
`endif

        // Reset asserted while waiting; the late response must be ignored.
        issue(3, 32'hDEADBEEF, 1'b0);
        #2;
        rst_ni    = 1'b0;
        abandoned = 1'b1;
        exp_q.delete();
        reset_checks();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        wait_drain();
        idle(2);
        // Normal operation resumes after reset.
        issue(2, 32'h5A5AA5A5, 1'b0);
        wait_drain();
        idle(2);

        finish_tb();
    end

endmodule
